// File: rtl/osc_req_ctrl_if.sv
// Requester-facing handshake bundle for osc_req_ctrl: level requests in,
// per-requester grants and the shared ready flag out.
interface osc_req_ctrl_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic               osc_ready;

  modport master (output req, input  ack, input  osc_ready);
  modport slave  (input  req, output ack, output osc_ready);
endinterface

// File: rtl/osc_req_ctrl.sv
// Oscillator enable controller shared by NUM_REQ requesters: powers the
// oscillator on demand, waits a fixed warm-up, keeps it on through short idle
// gaps and enforces a minimum off-time before any re-enable.
// Optional build macro OSC_STATS_EN adds a saturating oscillator-on counter.
module osc_req_ctrl #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WARMUP_CYC = 1024,
  parameter int unsigned HOLD_CYC   = 256,
  parameter int unsigned MINOFF_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  osc_req_ctrl_if.slave        bus,
  output logic                 osc_en,
  output logic                 busy,
  output logic [31:0]          on_cnt
);

  typedef enum logic [2:0] {
    S_OFF,
    S_WARMUP,
    S_ON,
    S_HOLD,
    S_COOL
  } state_e;

  // Reload values for the shared down-counter; the HOLD/MINOFF values are
  // only used when the corresponding parameter is non-zero.
  localparam logic [15:0] WARM_LD   = 16'(WARMUP_CYC - 1);
  localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYC - 1);
  localparam logic [15:0] MINOFF_LD = 16'(MINOFF_CYC - 1);

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 osc_en_q, osc_en_d;
  logic                 osc_ready_q, osc_ready_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 any_req;

  assign any_req = |bus.req;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_OFF: begin
        if (any_req) begin
          state_d = S_WARMUP;
          cnt_d   = WARM_LD;
        end
      end
      S_WARMUP: begin
        if (cnt_q == '0) state_d = S_ON;
        else             cnt_d   = cnt_q - 16'd1;
      end
      S_ON: begin
        if (!any_req) begin
          if (HOLD_CYC == 0) begin
            state_d = S_COOL;
            cnt_d   = MINOFF_LD;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end
        end
      end
      S_HOLD: begin
        // A request in the expiry cycle still wins over the drop to COOL.
        if (any_req) begin
          state_d = S_ON;
        end else if (cnt_q == '0) begin
          state_d = S_COOL;
          cnt_d   = MINOFF_LD;
        end else begin
          cnt_d   = cnt_q - 16'd1;
        end
      end
      S_COOL: begin
        if (MINOFF_CYC == 0 || cnt_q == '0) state_d = S_OFF;
        else                                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = S_OFF;
    endcase

    osc_en_d    = (state_d == S_WARMUP) || (state_d == S_ON) || (state_d == S_HOLD);
    osc_ready_d = (state_d == S_ON) || (state_d == S_HOLD);
    ack_d       = bus.req & {NUM_REQ{osc_ready_q}};
  end

  // State, counter and glitch-free output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      osc_en_q    <= 1'b0;
      osc_ready_q <= 1'b0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      osc_en_q    <= osc_en_d;
      osc_ready_q <= osc_ready_d;
      ack_q       <= ack_d;
    end
  end

  assign osc_en        = osc_en_q;
  assign bus.osc_ready = osc_ready_q;
  assign bus.ack       = ack_q;
  assign busy          = (state_q != S_OFF);

`ifdef OSC_STATS_EN
  logic [31:0] on_cnt_q;

  // Saturating count of cycles with the oscillator enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      on_cnt_q <= '0;
    end else if (osc_en_q && (on_cnt_q != '1)) begin
      on_cnt_q <= on_cnt_q + 32'd1;
    end
  end

  assign on_cnt = on_cnt_q;
`else
  assign on_cnt = '0;
`endif

endmodule

// File: tb/tb_osc_req_ctrl.sv
// Self-checking bench for osc_req_ctrl. Two instances share the same stimulus:
// A uses small timing values (16/8/4), B exercises the zero hold / zero
// min-off / single-cycle warm-up corner. Both are compared every cycle against
// an elapsed-time reference model; directed checks pin absolute latencies.
module tb_osc_req_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;

  logic        en_a, busy_a, en_b, busy_b;
  logic [31:0] on_a, on_b;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  osc_req_ctrl_if #(.NUM_REQ(4)) bus_a ();
  osc_req_ctrl_if #(.NUM_REQ(4)) bus_b ();

  assign bus_a.req = req;
  assign bus_b.req = req;

  osc_req_ctrl #(.NUM_REQ(4), .WARMUP_CYC(16), .HOLD_CYC(8), .MINOFF_CYC(4)) u_a (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_a),
    .osc_en (en_a),
    .busy   (busy_a),
    .on_cnt (on_a)
  );

  osc_req_ctrl #(.NUM_REQ(4), .WARMUP_CYC(1), .HOLD_CYC(0), .MINOFF_CYC(0)) u_b (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus_b),
    .osc_en (en_b),
    .busy   (busy_b),
    .on_cnt (on_b)
  );

  always #5 clk = ~clk;

  // Reference model: tracks enable/ready plus elapsed-time counters
  // (age since enable, consecutive idle cycles while ready, age since off).
  typedef struct {
    bit         en;
    bit         rdy;
    bit         cooling;
    int         warm_age;
    int         idle;
    int         off_age;
    logic [3:0] ack;
    longint     on;
  } mdl_t;

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};

  function automatic mdl_t mdl_step(mdl_t m, int W, int H, int M, logic rs, logic [3:0] rq);
    mdl_t n;
    bit   r;
    n = m;
    r = |rq;
    if (rs) begin
      n = '{default: 0};
    end else begin
      n.ack = rq & {4{m.rdy}};
      if (m.en) n.on = m.on + 1;
      if (!m.en) begin
        if (m.cooling) begin
          n.off_age = m.off_age + 1;
          if (n.off_age >= ((M > 0) ? M : 1)) n.cooling = 1'b0;
        end else if (r) begin
          n.en       = 1'b1;
          n.warm_age = 0;
        end
      end else if (!m.rdy) begin
        n.warm_age = m.warm_age + 1;
        if (n.warm_age == W) begin
          n.rdy  = 1'b1;
          n.idle = 0;
        end
      end else begin
        n.idle = r ? 0 : m.idle + 1;
        if (n.idle > H) begin
          n.en      = 1'b0;
          n.rdy     = 1'b0;
          n.cooling = 1'b1;
          n.off_age = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma = mdl_step(ma, 16, 8, 4, rst, req);
    mb = mdl_step(mb, 1, 0, 0, rst, req);
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  function automatic longint exp_on(longint v);
`ifdef OSC_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic compare_all();
    check_val("a_en",    64'(en_a),            64'(ma.en));
    check_val("a_ready", 64'(bus_a.osc_ready), 64'(ma.rdy));
    check_val("a_busy",  64'(busy_a),          64'(ma.en | ma.cooling));
    check_val("a_ack",   64'(bus_a.ack),       64'(ma.ack));
    check_val("a_oncnt", 64'(on_a),            64'(exp_on(ma.on)));
    check_val("b_en",    64'(en_b),            64'(mb.en));
    check_val("b_ready", 64'(bus_b.osc_ready), 64'(mb.rdy));
    check_val("b_busy",  64'(busy_b),          64'(mb.en | mb.cooling));
    check_val("b_ack",   64'(bus_b.ack),       64'(mb.ack));
    check_val("b_oncnt", 64'(on_b),            64'(exp_on(mb.on)));
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    tick(3);
    check_val("rst_en",    64'(en_a),            64'd0);
    check_val("rst_ready", 64'(bus_a.osc_ready), 64'd0);
    check_val("rst_busy",  64'(busy_a),          64'd0);
    check_val("rst_oncnt", 64'(on_a),            64'd0);
    rst = 1'b0;
    tick(6);

    // Single request: req raised in "cycle 10"
    req = 4'b0001;
    tick(1);                                           // cycle 11
    check_val("dir_en_rise", 64'(en_a), 64'd1);
    check_val("dir_rdy_early", 64'(bus_a.osc_ready), 64'd0);
    tick(15);                                          // cycle 26
    check_val("dir_rdy_26", 64'(bus_a.osc_ready), 64'd0);
    tick(1);                                           // cycle 27
    check_val("dir_rdy_27", 64'(bus_a.osc_ready), 64'd1);
    check_val("dir_ack_27", 64'(bus_a.ack), 64'd0);
    tick(1);                                           // cycle 28
    check_val("dir_ack_28", 64'(bus_a.ack), 64'h1);
    tick(12);                                          // cycle 40
    req = 4'b0000;
    tick(1);                                           // cycle 41
    check_val("dir_ack_drop", 64'(bus_a.ack), 64'h0);
    check_val("dir_hold_en", 64'(en_a), 64'd1);
    tick(3);                                           // cycle 44, 3 into HOLD
    req = 4'b0100;
    tick(1);                                           // cycle 45
    check_val("dir_rehold_rdy", 64'(bus_a.osc_ready), 64'd1);
    check_val("dir_ack2", 64'(bus_a.ack), 64'h4);
    req = 4'b0000;
    tick(8);                                           // cycle 53
    check_val("dir_hold_last", 64'(en_a), 64'd1);
    tick(1);                                           // cycle 54, COOL
    check_val("dir_en_fall", 64'(en_a), 64'd0);
    check_val("dir_cool_busy", 64'(busy_a), 64'd1);
    check_val("dir_oncnt", 64'(on_a), 64'(exp_on(43)));
    tick(1);                                           // cycle 55
    req = 4'b0010;
    tick(1);                                           // cycle 56
    check_val("dir_cool_en56", 64'(en_a), 64'd0);
    tick(2);                                           // cycle 58, OFF
    check_val("dir_cool_en58", 64'(en_a), 64'd0);
    check_val("dir_off_busy", 64'(busy_a), 64'd0);
    tick(1);                                           // cycle 59
    check_val("dir_reen", 64'(en_a), 64'd1);
    tick(15);
    check_val("dir_rewarm_rdy0", 64'(bus_a.osc_ready), 64'd0);
    tick(1);
    check_val("dir_rewarm_rdy1", 64'(bus_a.osc_ready), 64'd1);

    // Reset mid-warm-up with the request held
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check_val("rw_en", 64'(en_a), 64'd1);
    tick(4);                                           // warm-up cycle 5
    rst = 1'b1;
    tick(1);
    check_val("rw_rst_en",   64'(en_a),            64'd0);
    check_val("rw_rst_rdy",  64'(bus_a.osc_ready), 64'd0);
    check_val("rw_rst_busy", 64'(busy_a),          64'd0);
    check_val("rw_rst_ack",  64'(bus_a.ack),       64'd0);
    check_val("rw_rst_on",   64'(on_a),            64'd0);
    rst = 1'b0;
    tick(1);
    check_val("rw_fresh_en", 64'(en_a), 64'd1);
    tick(15);
    check_val("rw_fresh_rdy0", 64'(bus_a.osc_ready), 64'd0);
    tick(1);
    check_val("rw_fresh_rdy1", 64'(bus_a.osc_ready), 64'd1);
    req = 4'b0000;

    // Randomized segments: bursts, idle gaps of varied length, occasional reset
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 11) == 0) begin
        rst = 1'b1;
        tick($urandom_range(1, 2));
        rst = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) req = 4'($urandom);
      else                           req = 4'b0000;
      tick($urandom_range(1, 30));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/osc_req_ctrl.md
Name: osc_req_ctrl

Overview:
- Controller for the on-chip oscillator enable (OSCEN), shared between NUM_REQ independent requesters.
- Powers the oscillator up on demand and waits a fixed warm-up before declaring it usable.
- Keeps it running through short idle gaps (hold-off), and enforces a minimum off-time before any re-enable.
- Runs on an always-on system clock; sits between user logic and the oscillator wrapper's enable input.

Parameters:
- NUM_REQ, 4: number of requesters, 1..8.
- WARMUP_CYC, 1024: cycles from osc_en rising to osc_ready, 1..65535.
- HOLD_CYC, 256: idle cycles (no request) in ON before osc_en drops, 0..65535.
- MINOFF_CYC, 64: minimum cycles osc_en stays low after dropping, 0..65535.

Ports:
- clk  in  1  always-on system clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester level request; hold high while the oscillator is needed.
- ack  out  NUM_REQ  per-requester grant; ack[i] = req[i] & osc_ready, registered.
- osc_en  out  1  drives oscillator enable.
- osc_ready  out  1  oscillator warmed up and stable.
- busy  out  1  high in any state other than OFF.
- on_cnt  out  32  oscillator-on cycle count (only with OSC_STATS_EN; otherwise tied 0).

Behaviour:
- Reset: state=OFF; counter=0; osc_en=0, osc_ready=0, ack=0, busy=0, on_cnt=0. A reset asserted in any state returns to OFF on the next edge; no cool-down is applied after reset.
- any_req = OR of req, sampled each clk. One 16-bit down-counter is shared by all timed states.
- States and transitions:
  - OFF: osc_en=0. If any_req, go to WARMUP and load counter=WARMUP_CYC-1.
  - WARMUP: osc_en=1. Counter decrements. At counter==0, go to ON. Requests dropping mid-warm-up do not abort; warm-up always completes, then ON evaluates idle.
  - ON: osc_en=1, osc_ready=1.
    - If !any_req: if HOLD_CYC==0, go to COOL; else go to HOLD with counter=HOLD_CYC-1.
  - HOLD: osc_en=1, osc_ready=1. Counter decrements.
    - If any_req, return to ON (counter discarded).
    - Else at counter==0, go to COOL.
  - COOL: osc_en=0, osc_ready=0. Load counter=MINOFF_CYC-1 on entry and decrement.
    - Requests are held off.
    - At counter==0 (or immediately if MINOFF_CYC==0), go to OFF. OFF then re-enables on the next cycle if any_req is still high.
- Outputs:
  - osc_en and osc_ready are registered decodes of the next state; no glitches.
  - osc_ready rises exactly WARMUP_CYC cycles after osc_en rises.
- ack:
  - Registered: ack[i] is high the cycle after req[i] & osc_ready.
  - Deasserts the cycle after req[i] falls or osc_ready falls.
  - Every requester seeing osc_ready is acked at once; there is no priority, because the resource is shared, not exclusive.
- Simultaneous events:
  - A request arriving in the same cycle as the HOLD expiry keeps the oscillator in ON; the request wins.
  - A request arriving during COOL is not lost. It stays pending as a level and is served after the min-off period.
- busy = (state != OFF).

Optional Feature:
- Macro: OSC_STATS_EN.
- Defined:
  - on_cnt increments by 1 every cycle osc_en==1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst.
- Undefined: no counter logic is generated; on_cnt is driven constant 0.

Test Plan:
- Single request (WARMUP_CYC=16, HOLD_CYC=8, MINOFF_CYC=4): req=4'b0001 at cycle 10.
  - osc_en=1 at cycle 11.
  - osc_ready=1 at cycle 27.
  - ack[0]=1 at cycle 28.
- Release and hold (continues the single-request test): drop req at cycle 40.
  - ack[0]=0 at cycle 41.
  - osc_en stays 1 through HOLD and falls 9 cycles after ON exits.
  - osc_en stays 0 for 4 cycles minimum.
- Re-request during HOLD (continues the single-request test): raise req[2] 3 cycles into HOLD.
  - Returns to ON; osc_ready never drops; ack[2]=1 one cycle later.
- Request during COOL: raise req[1] one cycle into COOL.
  - osc_en stays 0 until COOL ends.
  - Then OFF→WARMUP; osc_ready 16 cycles after osc_en re-rises.
- Reset mid-warm-up: assert rst at warm-up cycle 5 with req held.
  - All outputs 0 next cycle.
  - After rst release, a fresh full 16-cycle warm-up occurs.
- OSC_STATS_EN: run the single-request test to osc_en fall.
  - on_cnt equals total osc_en-high cycles (16 warm-up + ON cycles + 9 hold).
  - Rebuild without the macro: on_cnt reads 0 throughout.
